// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential multiplier family.
// Holds the FSM state encoding, the legal operand width range, and a
// conditional two's-complement negate used for operand magnitudes and
// for the product sign fix-up.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int HELPER_W  = 2 * WIDTH_MAX;

    // Negate v when en is set. Callers sign- or zero-extend into HELPER_W
    // bits and cast the result back to their own width.
    function automatic logic [HELPER_W-1:0] cond_negate(input logic [HELPER_W-1:0] v,
                                                        input logic                en);
        return en ? (HELPER_W'(0) - v) : v;
    endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Datapath of the shift-add multiplier: operand magnitude capture,
// accumulator with its single adder, and the final sign fix-up into P.
// Build option SEQ_MULT_EARLY_TERM_EN adds a zero-detect on the shifted
// multiplier so the controller can stop as soon as no set bits remain.
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               finish,
    input  logic [CNT_W-1:0]   count,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               sgn,
    output logic               mplier_zero,
    output logic [2*WIDTH-1:0] P
);

    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    mplier;
    logic [PW-1:0]       acc;
    logic                neg;
    logic                a_neg;
    logic                b_neg;
    logic [HELPER_W-1:0] a_ext;
    logic [HELPER_W-1:0] b_ext;
    logic [WIDTH-1:0]    mag_a;
    logic [WIDTH-1:0]    mag_b;
    logic [PW-1:0]       addend;
    logic [PW-1:0]       acc_nxt;
    logic [PW-1:0]       p_fix;

    // Magnitudes: -2^(W-1) negates to 2^(W-1), which still fits unsigned.
    assign a_neg = sgn & A[WIDTH-1];
    assign b_neg = sgn & B[WIDTH-1];
    assign a_ext = {{(HELPER_W-WIDTH){a_neg}}, A};
    assign b_ext = {{(HELPER_W-WIDTH){b_neg}}, B};
    assign mag_a = WIDTH'(cond_negate(a_ext, a_neg));
    assign mag_b = WIDTH'(cond_negate(b_ext, b_neg));

    // One 2W-bit adder; the partial product is the multiplicand at bit 'count'.
    assign addend  = {{WIDTH{1'b0}}, mcand} << count;
    assign acc_nxt = mplier[0] ? (acc + addend) : acc;
    assign p_fix   = PW'(cond_negate(HELPER_W'(acc_nxt), neg));

`ifdef SEQ_MULT_EARLY_TERM_EN
    // High when the multiplier will be zero after this cycle's shift.
    assign mplier_zero = ~|mplier[WIDTH-1:1];
`else
    assign mplier_zero = 1'b0;
`endif

    // Operand capture on accept, one iteration per CALC cycle, P on the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            P      <= '0;
        end else if (load) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            acc    <= '0;
            neg    <= a_neg ^ b_neg;
        end else if (step) begin
            acc    <= acc_nxt;
            mplier <= mplier >> 1;
            if (finish) begin
                P <= p_fix;
            end
        end
    end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
// unsigned or signed per transaction, with valid/ready on both sides.
// Build option SEQ_MULT_EARLY_TERM_EN ends CALC once the remaining
// multiplier bits are all zero; P is the same either way.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The input side accepts only in IDLE (in_ready=1); operands are sampled
// at that edge only. out_valid rises with P and both stay unchanged until
// an edge with out_ready=1. in_valid outside IDLE and out_ready outside
// DONE are ignored.
module seq_shift_add_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               sgn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic [1:0]         dbg_state
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("seq_shift_add_multiplier: WIDTH out of range");
    end

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             fire;
    logic             step;
    logic             last_iter;
    logic             finish;
    logic             mplier_zero;

    assign fire      = (state == IDLE) && in_valid && in_ready;
    assign step      = (state == CALC);
    assign last_iter = (count == CNT_W'(WIDTH - 1)) || mplier_zero;
    assign finish    = step && last_iter;
    assign dbg_state = state;

    // Control FSM with registered handshake outputs and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= CALC;
                        in_ready <= 1'b0;
                        count    <= '0;
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
                    if (last_iter) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    seq_mult_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .load        (fire),
        .step        (step),
        .finish      (finish),
        .count       (count),
        .A           (A),
        .B           (B),
        .sgn         (sgn),
        .mplier_zero (mplier_zero),
        .P           (P)
    );

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: one WIDTH=2 and one WIDTH=8 instance
// sharing clock and reset. Inputs are driven and outputs sampled on the
// falling edge. Expected latency follows SEQ_MULT_EARLY_TERM_EN.
module tb_seq_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid2 = 1'b0, in_ready2, sgn2 = 1'b0, out_valid2, out_ready2 = 1'b0;
    logic [1:0]  a2 = '0, b2 = '0, dbg2;
    logic [3:0]  p2;

    logic        in_valid8 = 1'b0, in_ready8, sgn8 = 1'b0, out_valid8, out_ready8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [1:0]  dbg8;
    logic [15:0] p8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_shift_add_multiplier #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .A(a2), .B(b2), .sgn(sgn2), .out_valid(out_valid2), .out_ready(out_ready2),
        .P(p2), .dbg_state(dbg2)
    );

    seq_shift_add_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(a8), .B(b8), .sgn(sgn8), .out_valid(out_valid8), .out_ready(out_ready8),
        .P(p8), .dbg_state(dbg8)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Expected CALC cycle count (edges from accept to out_valid visible).
    function automatic int exp_lat8(input logic [7:0] b, input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
        logic [7:0] m;
        int l;
        m = (s && b[7]) ? (8'd0 - b) : b;
        l = 1;
        for (int i = 0; i < 8; i++) if (m[i]) l = i + 1;
        return l;
`else
        return 8 + 0 * int'({b, s});
`endif
    endfunction

    function automatic int exp_lat2(input logic [1:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
        return (b[1]) ? 2 : 1;
`else
        return 2 + 0 * int'(b);
`endif
    endfunction

    // Driver: one transaction on the 8-bit DUT; entered and left at a negedge.
    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input bit ack, output logic [15:0] p, output int lat);
        int guard;
        guard = 0;
        while (!in_ready8 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_valid8 = 1'b1; a8 = a; b8 = b; sgn8 = s;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        sgn8 = 1'($urandom_range(0, 1));
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid8 && lat < 100);
        p = p8;
        if (!out_valid8) begin
            checks++; errors++;
            $display("FAIL timeout8: out_valid=%0b after %0d cycles, required 1", out_valid8, lat);
        end
        if (ack) begin
            out_ready8 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready8 = 1'b0;
        end
    endtask

    task automatic drive2(input logic [1:0] a, input logic [1:0] b,
                          output logic [3:0] p, output int lat);
        int guard;
        guard = 0;
        while (!in_ready2 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_valid2 = 1'b1; a2 = a; b2 = b; sgn2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        a2 = 2'($urandom_range(0, 3));
        b2 = 2'($urandom_range(0, 3));
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid2 && lat < 100);
        p = p2;
        if (!out_valid2) begin
            checks++; errors++;
            $display("FAIL timeout2: out_valid=%0b after %0d cycles, required 1", out_valid2, lat);
        end
        out_ready2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8: got %0b want 0", out_valid8); end
        checks++; if (p8 !== 16'h0) begin errors++; $display("FAIL reset_p8: got %h want 0000", p8); end
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready8: got %0b want 1", in_ready8); end
        checks++; if (dbg8 !== 2'd0) begin errors++; $display("FAIL reset_state8: got %0d want 0", dbg8); end
        checks++; if ({out_valid2, in_ready2, p2} !== 6'b01_0000) begin
            errors++; $display("FAIL reset_dut2: got ov=%0b ir=%0b p=%h want ov=0 ir=1 p=0", out_valid2, in_ready2, p2);
        end
        rst = 1'b0;
    endtask

    task automatic test_exhaustive_w2();
        logic [3:0] p;
        int lat;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                drive2(2'(a), 2'(b), p, lat);
                checks++; if (p !== 4'(a * b)) begin
                    errors++; $display("FAIL w2_prod %0d*%0d: got %0d want %0d", a, b, p, a * b);
                end
                checks++; if (lat !== exp_lat2(2'(b))) begin
                    errors++; $display("FAIL w2_lat %0d*%0d: got %0d want %0d", a, b, lat, exp_lat2(2'(b)));
                end
            end
        end
    endtask

    task automatic run_table8(input string name, input logic [7:0] ta[6], input logic [7:0] tb[6],
                              input logic ts[6], input logic [15:0] tp[6]);
        logic [15:0] p;
        int lat;
        for (int i = 0; i < 6; i++) begin
            drive8(ta[i], tb[i], ts[i], 1'b1, p, lat);
            checks++; if (p !== tp[i]) begin
                errors++; $display("FAIL %s_prod[%0d] A=%h B=%h sgn=%0b: got %h want %h", name, i, ta[i], tb[i], ts[i], p, tp[i]);
            end
            checks++; if (lat !== exp_lat8(tb[i], ts[i])) begin
                errors++; $display("FAIL %s_lat[%0d]: got %0d want %0d", name, i, lat, exp_lat8(tb[i], ts[i]));
            end
        end
    endtask

    task automatic test_corners_w8();
        logic [7:0]  ta[6] = '{8'hFF, 8'h80, 8'hFD, 8'h7F, 8'hFD, 8'hFF};
        logic [7:0]  tb[6] = '{8'hFF, 8'h80, 8'h07, 8'h80, 8'h07, 8'hFF};
        logic        ts[6] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
        logic [15:0] tp[6] = '{16'hFE01, 16'h4000, 16'hFFEB, 16'hC080, 16'h06EB, 16'h0001};
        run_table8("w8", ta, tb, ts, tp);
    endtask

    task automatic test_early_term();
        logic [7:0]  ta[6] = '{8'h03, 8'h03, 8'h03, 8'h80, 8'h80, 8'h05};
        logic [7:0]  tb[6] = '{8'h00, 8'h01, 8'h80, 8'h00, 8'hFF, 8'h06};
        logic        ts[6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
        logic [15:0] tp[6] = '{16'h0000, 16'h0003, 16'h0180, 16'h0000, 16'h0080, 16'h001E};
        run_table8("et", ta, tb, ts, tp);
    endtask

    task automatic test_backpressure();
        logic [15:0] p;
        int lat;
        drive8(8'd12, 8'd10, 1'b0, 1'b0, p, lat);
        checks++; if (p !== 16'd120) begin errors++; $display("FAIL bp_prod: got %0d want 120", p); end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sgn8 = 1'b1; end
            if (i == 2) in_valid8 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checks++; if ({out_valid8, in_ready8, p8} !== {1'b1, 1'b0, 16'd120}) begin
                errors++; $display("FAIL bp_hold[%0d]: got ov=%0b ir=%0b p=%0d want ov=1 ir=0 p=120", i, out_valid8, in_ready8, p8);
            end
        end
        out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready8 = 1'b0;
        checks++; if ({out_valid8, in_ready8, dbg8} !== {1'b0, 1'b1, 2'd0}) begin
            errors++; $display("FAIL bp_release: got ov=%0b ir=%0b st=%0d want ov=0 ir=1 st=0", out_valid8, in_ready8, dbg8);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [15:0] p;
        int lat;
        bit seen;
        in_valid8 = 1'b1; a8 = 8'd9; b8 = 8'd9; sgn8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({dbg8, p8, in_ready8} !== {2'd0, 16'd0, 1'b1}) begin
            errors++; $display("FAIL rst_calc_state: got st=%0d p=%0d ir=%0b want st=0 p=0 ir=1", dbg8, p8, in_ready8);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid8) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_calc_no_valid: got out_valid seen=%0b want 0", seen); end
        drive8(8'd5, 8'd6, 1'b0, 1'b1, p, lat);
        checks++; if (p !== 16'd30) begin errors++; $display("FAIL rst_calc_next_prod: got %0d want 30", p); end
        checks++; if (lat !== exp_lat8(8'd6, 1'b0)) begin
            errors++; $display("FAIL rst_calc_next_lat: got %0d want %0d", lat, exp_lat8(8'd6, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive_w2();
        test_corners_w8();
        test_early_term();
        test_backpressure();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
